// File: rtl/axi_pkg.sv
// Shared AXI read encodings, responder FSM states and the burst address step.
// Optional error checking in the responder is enabled by AXI_RD_ERR_CHK_EN.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StFetch,
        StData
    } rd_state_e;

    // Address of the following beat; size must already be clamped to the bus width.
    function automatic logic [63:0] next_addr(logic [63:0] addr, logic [2:0] size,
                                              logic [7:0] len, logic [1:0] burst);
        logic [63:0] sum;
        logic [63:0] mask;
        sum  = addr + (64'd1 << size);
        mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (sum & mask);
            default:     next_addr = sum;
        endcase
    endfunction

    function automatic logic wrap_len_ok(logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read address and read data channels between a read master and a responder.
interface axi_rd_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Latches a burst descriptor and steps the beat address and beat counter.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [7:0]        len_i,
    input  logic [1:0]        burst_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        len_o,
    output logic [1:0]        burst_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic [1:0]        burst_q, burst_d;

    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        len_d   = len_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        if (load_i) begin
            addr_d  = addr_i;
            size_d  = size_i;
            len_d   = len_i;
            burst_d = burst_i;
            beat_d  = '0;
        end else if (step_i) begin
            addr_d = ADDR_W'(next_addr(64'(addr_q), size_q, len_q, burst_q));
            beat_d = beat_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            size_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
        end
    end

    assign addr_o  = addr_q;
    assign len_o   = len_q;
    assign burst_o = burst_q;
    assign last_o  = (beat_q == len_q);
endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder in front of a synchronous SRAM, one burst at a time.
// Define AXI_RD_ERR_CHK_EN to return SLVERR for out-of-window or malformed bursts.
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1c00_0000),
    parameter int unsigned       MEM_AW    = 14,
    parameter int unsigned       WAIT_CYC  = 0
) (
    input  logic               clk,
    input  logic               resetn,
    axi_rd_responder_if.slave  axi,
    output logic               mem_en,
    output logic [MEM_AW-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_rdata
);
    localparam int unsigned SHIFT    = $clog2(DATA_W / 8);
    localparam logic [2:0]  MAX_SIZE = 3'(SHIFT);

    rd_state_e         state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              arready_q, arready_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, data_now;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              fresh_q, fresh_d;

    logic              load, step, last, beat_err;
    logic [2:0]        eff_size;
    logic [ADDR_W-1:0] cur_addr, offset;
    logic [7:0]        cur_len;
    logic [1:0]        cur_burst;

    assign eff_size = (axi.arsize > MAX_SIZE) ? MAX_SIZE : axi.arsize;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .load_i  (load),
        .addr_i  (axi.araddr),
        .size_i  (eff_size),
        .len_i   (axi.arlen),
        .burst_i (axi.arburst),
        .step_i  (step),
        .addr_o  (cur_addr),
        .len_o   (cur_len),
        .burst_o (cur_burst),
        .last_o  (last)
    );

    assign offset = cur_addr - BASE_ADDR;

`ifdef AXI_RD_ERR_CHK_EN
    localparam int unsigned WIN_BITS = MEM_AW + SHIFT;
    assign beat_err = (cur_addr < BASE_ADDR) || ((64'(offset) >> WIN_BITS) != 64'd0) ||
                      (cur_burst == 2'b11) ||
                      ((cur_burst == BURST_WRAP) && !wrap_len_ok(cur_len));
`else
    logic unused_cfg;
    assign unused_cfg = ^{cur_len, cur_burst, offset};
    assign beat_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rid_d   = rid_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (axi.arvalid && arready_q) begin
                    load    = 1'b1;
                    rid_d   = axi.arid;
                    wait_d  = '0;
                    state_d = (WAIT_CYC > 0) ? StWait : StFetch;
                end
            end
            StWait: begin
                if (32'(wait_q) == WAIT_CYC - 1) state_d = StFetch;
                else                             wait_d  = wait_q + 4'd1;
            end
            StFetch: begin
                rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
                rlast_d = last;
                state_d = StData;
            end
            StData: begin
                if (axi.rready) begin
                    if (last) begin
                        state_d = StIdle;
                    end else begin
                        step    = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        arready_d = (state_d == StIdle);
        fresh_d   = (state_q == StFetch);
    end

    // SRAM data arrives in the first DATA cycle; pass it through then hold it.
    assign data_now = (rresp_q == RESP_SLVERR) ? '0 : mem_rdata;
    assign rdata_d  = fresh_q ? data_now : rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            arready_q <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            fresh_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            arready_q <= arready_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            fresh_q   <= fresh_d;
        end
    end

    assign axi.arready = arready_q;
    assign axi.rvalid  = (state_q == StData);
    assign axi.rid     = rid_q;
    assign axi.rdata   = fresh_q ? data_now : rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
    assign mem_en      = (state_q == StFetch) && !beat_err;
    assign mem_addr    = mem_en ? offset[SHIFT +: MEM_AW] : '0;
endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder with an SRAM model and an expected-beat queue.
// Expectations follow AXI_RD_ERR_CHK_EN when it is defined for the build.
module tb_axi_rd_responder;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = 4;
    localparam int unsigned MAW = 14;
    localparam logic [31:0] BASE = 32'h1c00_0000;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            mem_en;
    logic [MAW-1:0]  mem_addr;
    logic [DW-1:0]   mem_rdata = '0;
    logic [31:0]     mem [0:16383];
    beat_t           sb [$];
    int              vectors = 0;
    int              miscompares = 0;
    int              waited;
    logic            seen;

    axi_rd_responder_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

    axi_rd_responder #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ID_W      (IW),
        .BASE_ADDR (BASE),
        .MEM_AW    (MAW),
        .WAIT_CYC  (0)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .axi       (bus.slave),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_addr(logic [31:0] start, int beat, int size, int len,
                                               logic [1:0] burst);
        int unsigned bytes;
        int unsigned blk;
        logic [31:0] lo;
        bytes = 1 << ((size > 2) ? 2 : size);
        case (burst)
            2'b00: return start;
            2'b10: begin
                blk = 32'(len + 1) * bytes;
                lo  = start - (start % blk);
                return lo + ((start - lo + 32'(beat) * bytes) % blk);
            end
            default: return start + 32'(beat) * bytes;
        endcase
    endfunction

    task automatic push_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int size, input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] off;
        logic        err;
        beat_t       e;
        for (int b = 0; b <= len; b++) begin
            a   = model_addr(addr, b, size, len, burst);
            off = a - BASE;
            err = 1'b0;
`ifdef AXI_RD_ERR_CHK_EN
            err = (a < BASE) || (off >= 32'h0001_0000) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
`endif
            e.id   = id;
            e.data = err ? 32'h0 : mem[off[15:2]];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (b == len);
            sb.push_back(e);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst);
        int n = 0;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arsize  = 3'(size);
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        push_burst(id, addr, len, size, burst);
        while (!bus.arready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ar_accept", 64'(bus.arready), 64'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    // Waits for a beat, stalls it for the requested cycles, then accepts and checks it.
    task automatic recv_beat(input int stalls, output int wait_cyc);
        beat_t e;
        int    n = 0;
        bus.rready = (stalls == 0);
        while (!bus.rvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        wait_cyc = n;
        check("rvalid", 64'(bus.rvalid), 64'd1);
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        for (int s = 0; s < stalls; s++) begin
            check("stall_rvalid", 64'(bus.rvalid), 64'd1);
            check("stall_rdata", 64'(bus.rdata), 64'(e.data));
            check("stall_rid", 64'(bus.rid), 64'(e.id));
            check("stall_rlast", 64'(bus.rlast), 64'(e.last));
            check("stall_arready", 64'(bus.arready), 64'd0);
            @(posedge clk); #1;
        end
        bus.rready = 1'b1;
        check("rid", 64'(bus.rid), 64'(e.id));
        check("rdata", 64'(bus.rdata), 64'(e.data));
        check("rresp", 64'(bus.rresp), 64'(e.resp));
        check("rlast", 64'(bus.rlast), 64'(e.last));
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    initial begin
        for (int w = 0; w < 16384; w++) mem[w] = (32'(w) * 32'h9e37_79b1) ^ 32'h1357_2468;
        mem[0] = 32'h0280_1405;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", 64'(bus.arready), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_rlast", 64'(bus.rlast), 64'd0);
        check("rst_rresp", 64'(bus.rresp), 64'd0);
        check("rst_rid", 64'(bus.rid), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("idle_arready", 64'(bus.arready), 64'd1);

        // Single beat, rvalid two edges after the AR handshake
        send_ar(4'h1, BASE, 0, 2, 2'b01);
        recv_beat(0, waited);
        check("t1_latency", 64'(waited), 64'd1);
        check("t1_drained", 64'(sb.size()), 64'd0);

        // INCR x4: one beat per two cycles, arready only after the last beat
        send_ar(4'h2, BASE + 32'h10, 3, 2, 2'b01);
        for (int b = 0; b < 4; b++) begin
            recv_beat(0, waited);
            check("t2_rate", 64'(waited), 64'd1);
            check("t2_arready", 64'(bus.arready), 64'(b == 3));
        end

        // WRAP x4 from word 6: words 6,7,4,5
        send_ar(4'h3, BASE + 32'h18, 3, 2, 2'b10);
        for (int b = 0; b < 4; b++) recv_beat(0, waited);

        // Stalled beats with a second AR held pending
        send_ar(4'h4, BASE + 32'h40, 1, 2, 2'b01);
        bus.arid = 4'h5; bus.araddr = BASE + 32'h80; bus.arlen = 8'd0;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        push_burst(4'h5, BASE + 32'h80, 0, 2, 2'b01);
        recv_beat(2, waited);
        check("t4_ar_blocked", 64'(bus.arready), 64'd0);
        recv_beat(2, waited);
        check("t4_ar_ready", 64'(bus.arready), 64'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        check("t4_ar_taken", 64'(bus.arready), 64'd0);
        recv_beat(0, waited);

        // Oversized arsize behaves as full-width beats; FIXED repeats one word
        send_ar(4'h6, BASE + 32'h100, 2, 3, 2'b01);
        for (int b = 0; b < 3; b++) recv_beat(0, waited);
        send_ar(4'h7, BASE + 32'h20, 2, 2, 2'b00);
        for (int b = 0; b < 3; b++) recv_beat(0, waited);

        // Crossing the top of the window, and an address below the window
        send_ar(4'h8, BASE + 32'hfffc, 1, 2, 2'b01);
        for (int b = 0; b < 2; b++) recv_beat(0, waited);
        send_ar(4'h9, 32'h0, 1, 2, 2'b01);
        for (int b = 0; b < 2; b++) recv_beat(0, waited);

        // Maximum 256-beat burst
        send_ar(4'ha, BASE + 32'h400, 255, 2, 2'b01);
        for (int b = 0; b < 256; b++) recv_beat(0, waited);
        check("t9_drained", 64'(sb.size()), 64'd0);
        check("t9_idle", 64'(bus.arready), 64'd1);

        // Reset while beat 2 of an 8-beat burst is presented
        send_ar(4'hb, BASE + 32'h200, 7, 2, 2'b01);
        recv_beat(0, waited);
        while (!bus.rvalid && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("t10_beat2_valid", 64'(bus.rvalid), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("t10_rvalid_drop", 64'(bus.rvalid), 64'd0);
        check("t10_mem_en_drop", 64'(mem_en), 64'd0);
        check("t10_arready_rst", 64'(bus.arready), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        check("t10_arready", 64'(bus.arready), 64'd1);
        bus.rready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | bus.rvalid;
            @(posedge clk); #1;
        end
        check("t10_no_stale", 64'(seen), 64'd0);
        bus.rready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
